// File: rtl/lsu_wb_master.sv
// MEM-stage load/store unit: issues one Wishbone B4 classic cycle per access,
// formats load data, stalls the pipeline while busy, flags misalignment and bus errors.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_to_reg_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  fun3_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rd2_mem,
  output logic [31:0] load_data_mem,
  output logic        stall_pipl,
  output logic        misaligned,
  output logic        bus_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    off_q, off_d;
  size_e         size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ld_q, ld_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic          req;
  size_e         size_req;
  logic          misal_req;
  logic [3:0]    sel_req;
  logic [31:0]   dat_req;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   fmt_data;
  logic [CW-1:0] cnt_inc;
  logic          timed_out;

  assign req        = mem_to_reg_mem | mem_write_mem;
  assign stall_pipl = req & (state_q != DONE);

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = {adr_q, 2'b00};
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign load_data_mem = ld_q;
  assign misaligned    = mis_q;
  assign bus_err       = berr_q;

  // Request decode: size, alignment, byte lanes and replicated store data.
  always_comb begin
    size_req  = SZ_W;
    misal_req = 1'b0;
    sel_req   = 4'b1111;
    dat_req   = rd2_mem;
    case (fun3_mem)
      3'b000, 3'b100: size_req = SZ_B;
      3'b001, 3'b101: size_req = SZ_H;
      default:        size_req = SZ_W;
    endcase
    case (size_req)
      SZ_B: begin
        sel_req = 4'b0001 << alu_result_mem[1:0];
        dat_req = {4{rd2_mem[7:0]}};
      end
      SZ_H: begin
        misal_req = alu_result_mem[0];
        sel_req   = 4'b0011 << {alu_result_mem[1], 1'b0};
        dat_req   = {2{rd2_mem[15:0]}};
      end
      default: begin
        misal_req = (alu_result_mem[1:0] != 2'b00);
        sel_req   = 4'b1111;
        dat_req   = rd2_mem;
      end
    endcase
  end

  // Lane select and extension use the offset/size latched at request time.
  always_comb begin
    lane_b = wb_dat_i[{off_q, 3'b000} +: 8];
    lane_h = wb_dat_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_B:    fmt_data = {{24{sgn_q & lane_b[7]}}, lane_b};
      SZ_H:    fmt_data = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: fmt_data = wb_dat_i;
    endcase
  end

  assign cnt_inc   = cnt_q + 1'b1;
  assign timed_out = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misal_req) begin
            state_d = DONE;
            mis_d   = 1'b1;
            ld_d    = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = mem_write_mem;
            adr_d   = alu_result_mem[31:2];
            dat_d   = dat_req;
            sel_d   = sel_req;
            off_d   = alu_result_mem[1:0];
            size_d  = size_req;
            sgn_d   = ~fun3_mem[2];
            cnt_d   = '0;
          end
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = fmt_data;
        end else if (wb_err_i || timed_out) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ld_d    = '0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      off_q   <= '0;
      size_q  <= SZ_W;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Bench for lsu_wb_master: directed vector table, reset-in-BUS sequence and
// randomized accesses checked against a behavioural model.
module tb_lsu_wb_master;

  localparam int unsigned TO = 4;
  localparam int unsigned R_ACK  = 0;
  localparam int unsigned R_ERR  = 1;
  localparam int unsigned R_BOTH = 2;
  localparam int unsigned R_NONE = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_to_reg_mem, mem_write_mem;
  logic [2:0]  fun3_mem;
  logic [31:0] alu_result_mem, rd2_mem;
  logic [31:0] load_data_mem;
  logic        stall_pipl, misaligned, bus_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  lsu_wb_master #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_to_reg_mem (mem_to_reg_mem),
    .mem_write_mem  (mem_write_mem),
    .fun3_mem       (fun3_mem),
    .alu_result_mem (alu_result_mem),
    .rd2_mem        (rd2_mem),
    .load_data_mem  (load_data_mem),
    .stall_pipl     (stall_pipl),
    .misaligned     (misaligned),
    .bus_err        (bus_err),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int unsigned waits;
    int unsigned resp;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] ldv;
    logic        mis;
    logic        berr;
    int unsigned stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rd2,
                              input logic [31:0] rdata, input int unsigned waits,
                              input int unsigned resp, input logic [3:0] sel,
                              input logic [31:0] dat, input logic [31:0] ldv,
                              input logic mis, input logic berr, input int unsigned stall);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
    v.waits = waits; v.resp = resp; v.sel = sel; v.dat = dat; v.ldv = ldv;
    v.mis = mis; v.berr = berr; v.stall = stall;
    return v;
  endfunction

  // Reference model: expected results from access size, offset and slave response.
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int unsigned nbytes;
    int unsigned a;
    logic [31:0] b, h, fmt;
    logic ok;
    case (v.f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      default:    nbytes = 4;
    endcase
    a = int'(v.addr[1:0]);
    v.mis = (nbytes == 2 && (a % 2) != 0) || (nbytes == 4 && a != 0);
    b = (v.rdata >> (8 * a)) & 32'hFF;
    h = (v.rdata >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
    if (nbytes == 1) begin
      v.sel = 4'(1 << a);
      v.dat = {24'h0, v.rd2[7:0]} * 32'h01010101;
      fmt   = (!v.f3[2] && b >= 128) ? (b | 32'hFFFFFF00) : b;
    end else if (nbytes == 2) begin
      v.sel = (a >= 2) ? 4'b1100 : 4'b0011;
      v.dat = {16'h0, v.rd2[15:0]} * 32'h00010001;
      fmt   = (!v.f3[2] && h >= 32768) ? (h | 32'hFFFF0000) : h;
    end else begin
      v.sel = 4'b1111;
      v.dat = v.rd2;
      fmt   = v.rdata;
    end
    ok = (v.resp == R_ACK) || (v.resp == R_BOTH);
    if (v.mis) begin
      v.ldv = 32'h0; v.berr = 1'b0; v.stall = 1;
    end else begin
      v.ldv   = ok ? fmt : 32'h0;
      v.berr  = !ok;
      v.stall = 1 + ((v.resp == R_NONE) ? TO : v.waits + 1);
    end
    return v;
  endfunction

  task automatic clear_req();
    mem_to_reg_mem = 1'b0; mem_write_mem = 1'b0;
    fun3_mem = 3'b0; alu_result_mem = 32'h0; rd2_mem = 32'h0;
  endtask

  // One access: request presented at the IDLE-cycle negedge, slave responds
  // in BUS cycle waits+1, results checked in the DONE cycle.
  task automatic run(input vec_t v, input string tag);
    int unsigned stalls, busn;
    bit done;
    @(negedge clk);
    chk({tag, ".idle_mis"}, misaligned, 1'b0);
    chk({tag, ".idle_berr"}, bus_err, 1'b0);
    chk({tag, ".idle_cyc"}, wb_cyc_o, 1'b0);
    mem_to_reg_mem = v.ld; mem_write_mem = v.st; fun3_mem = v.f3;
    alu_result_mem = v.addr; rd2_mem = v.rd2; wb_dat_i = v.rdata;
    #1;
    chk({tag, ".stall_req"}, stall_pipl, 1'b1);
    stalls = 1; busn = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall_pipl) begin
        stalls++; busn++;
        chk({tag, ".bus_cyc"}, {wb_cyc_o, wb_stb_o}, 2'b11);
        if (busn == 1) begin
          chk({tag, ".adr"}, wb_adr_o, v.addr & 32'hFFFF_FFFC);
          chk({tag, ".sel"}, wb_sel_o, v.sel);
          chk({tag, ".dat_o"}, wb_dat_o, v.dat);
          chk({tag, ".we"}, wb_we_o, v.st);
        end
        if (busn == v.waits + 1 && v.resp != R_NONE) begin
          wb_ack_i = (v.resp == R_ACK) || (v.resp == R_BOTH);
          wb_err_i = (v.resp == R_ERR) || (v.resp == R_BOTH);
        end else begin
          wb_ack_i = 1'b0; wb_err_i = 1'b0;
        end
      end else begin
        done = 1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk({tag, ".stall_cycles"}, stalls, v.stall);
        chk({tag, ".done_cyc"}, {wb_cyc_o, wb_stb_o}, 2'b00);
        chk({tag, ".misaligned"}, misaligned, v.mis);
        chk({tag, ".bus_err"}, bus_err, v.berr);
        if (v.ld || v.mis) chk({tag, ".load_data"}, load_data_mem, v.ldv);
        clear_req();
      end
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL %s.no_done: got stall still high expected DONE within 40 cycles", tag);
      wb_ack_i = 1'b0; wb_err_i = 1'b0;
      clear_req();
    end
  endtask

  vec_t tbl[17];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 0, 3'b000, 32'h1003, 32'h0,        32'h80123456, 0, R_ACK,  4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 2);
    tbl[1]  = mk(0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0,        3, R_ACK,  4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 5);
    tbl[2]  = mk(1, 0, 3'b010, 32'h3001, 32'h0,        32'h0,        0, R_ACK,  4'b0000, 32'h0,        32'h0,        1, 0, 1);
    tbl[3]  = mk(1, 0, 3'b010, 32'h4000, 32'h0,        32'h55555555, 1, R_ERR,  4'b1111, 32'h0,        32'h0,        0, 1, 3);
    tbl[4]  = mk(1, 0, 3'b010, 32'h4004, 32'h0,        32'h12345678, 0, R_BOTH, 4'b1111, 32'h0,        32'h12345678, 0, 0, 2);
    tbl[5]  = mk(1, 0, 3'b010, 32'h5000, 32'h0,        32'h0,        0, R_NONE, 4'b1111, 32'h0,        32'h0,        0, 1, 5);
    tbl[6]  = mk(1, 0, 3'b010, 32'h0000, 32'h0,        32'h11223344, 0, R_ACK,  4'b1111, 32'h0,        32'h11223344, 0, 0, 2);
    tbl[7]  = mk(1, 0, 3'b101, 32'h0002, 32'h0,        32'h9ABC1234, 0, R_ACK,  4'b1100, 32'h0,        32'h00009ABC, 0, 0, 2);
    tbl[8]  = mk(1, 0, 3'b001, 32'h0002, 32'h0,        32'h9ABC1234, 1, R_ACK,  4'b1100, 32'h0,        32'hFFFF9ABC, 0, 0, 3);
    tbl[9]  = mk(1, 0, 3'b100, 32'h0001, 32'h0,        32'h0000F000, 0, R_ACK,  4'b0010, 32'h0,        32'h000000F0, 0, 0, 2);
    tbl[10] = mk(0, 1, 3'b000, 32'h0101, 32'h123456A5, 32'h0,        2, R_ACK,  4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 4);
    tbl[11] = mk(0, 1, 3'b010, 32'h0008, 32'hDEADBEEF, 32'h0,        0, R_ACK,  4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 2);
    tbl[12] = mk(1, 0, 3'b001, 32'h0011, 32'h0,        32'h0,        0, R_ACK,  4'b0000, 32'h0,        32'h0,        1, 0, 1);
    tbl[13] = mk(1, 0, 3'b011, 32'h0020, 32'h0,        32'hCAFEF00D, 0, R_ACK,  4'b1111, 32'h0,        32'hCAFEF00D, 0, 0, 2);
    tbl[14] = mk(0, 1, 3'b111, 32'h0022, 32'h1,        32'h0,        0, R_ACK,  4'b0000, 32'h0,        32'h0,        1, 0, 1);
    tbl[15] = mk(1, 0, 3'b000, 32'h0000, 32'h0,        32'h0000007F, 0, R_ACK,  4'b0001, 32'h0,        32'h0000007F, 0, 0, 2);
    tbl[16] = mk(1, 0, 3'b001, 32'h0000, 32'h0,        32'h00008001, 0, R_ACK,  4'b0011, 32'h0,        32'hFFFF8001, 0, 0, 2);

    reset_n = 1'b0;
    clear_req();
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #2;
    chk("rst.bus_ctl", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    chk("rst.adr", wb_adr_o, 32'h0);
    chk("rst.dat_o", wb_dat_o, 32'h0);
    chk("rst.sel", wb_sel_o, 4'h0);
    chk("rst.load_data", load_data_mem, 32'h0);
    chk("rst.pulses", {misaligned, bus_err}, 2'b00);
    chk("rst.stall_noreq", stall_pipl, 1'b0);
    mem_to_reg_mem = 1'b1;
    #1;
    chk("rst.stall_req", stall_pipl, 1'b1);
    clear_req();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Reset asserted mid-BUS with a late ack arriving during/after reset.
    @(negedge clk);
    mem_to_reg_mem = 1'b1; fun3_mem = 3'b010; alu_result_mem = 32'h6000;
    @(negedge clk);
    chk("rstbus.cyc1", wb_cyc_o, 1'b1);
    @(negedge clk);
    chk("rstbus.cyc2", wb_cyc_o, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstbus.async_drop", {wb_cyc_o, wb_stb_o}, 2'b00);
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    clear_req();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstbus.after_cyc", wb_cyc_o, 1'b0);
    chk("rstbus.after_ld", load_data_mem, 32'h0);
    chk("rstbus.after_berr", bus_err, 1'b0);
    wb_ack_i = 1'b0;
    run(tbl[7], "post_rst_lhu");

    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      rv.ld    = 1'($urandom_range(0, 1));
      rv.st    = !rv.ld;
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.rd2   = $urandom;
      rv.rdata = $urandom;
      rv.waits = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      rv.resp  = (r < 7) ? R_ACK : (r == 7) ? R_ERR : (r == 8) ? R_BOTH : R_NONE;
      rv = model(rv);
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
